// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between an external controller (master) and spi_reg_ctrl (slave).
interface spi_reg_ctrl_if;
  logic sclk_in;
  logic copi_in;
  logic ncs_in;
  logic cipo_out;

  modport master (output sclk_in, output copi_in, output ncs_in, input cipo_out);
  modport slave  (input sclk_in, input copi_in, input ncs_in, output cipo_out);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 peripheral writing a 5-entry PWM/output configuration register file.
// Frames are 16 bits, MSB first: R/W (1 = write), 7-bit address, 8-bit data.
// SPI pins are asynchronous; everything runs on clk after the synchronisers.
// Optional feature: define SPI_READBACK_EN to enable register readback on cipo_out.
//
// state  | meaning
// IDLE   | waiting for ncs falling edge
// SHIFT  | ncs low, shifting COPI on SCLK rising edges
// COMMIT | one clk: apply a valid write frame, then back to IDLE
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4,
  parameter int FRAME_BITS  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_ctrl_if.slave  spi,
  output logic [7:0]     en_reg_out_7_0,
  output logic [7:0]     en_reg_out_15_8,
  output logic [7:0]     en_reg_pwm_7_0,
  output logic [7:0]     en_reg_pwm_15_8,
  output logic [7:0]     pwm_duty_cycle,
  output logic           cfg_update
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT   = 5'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             regs_q [0:4];
  logic                   cfg_update_q;

  logic                   frame_rw;
  logic [6:0]             frame_addr;
  logic [7:0]             frame_data;
  logic                   reg_we;

  // Synchronise the SPI pins and keep a delayed copy of the last stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk_in};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi_in};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs_in};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  assign frame_rw   = shift_q[FRAME_BITS-1];
  assign frame_addr = shift_q[FRAME_BITS-2 -: 7];
  assign frame_data = shift_q[7:0];
  assign reg_we     = (state_q == COMMIT) && frame_rw && (frame_addr <= 7'(MAX_ADDR));

  // FSM, shift register and bit counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a bit arriving with the ncs rising edge is counted before the length check
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
        if (ncs_rise) state_d = (cnt_d == CNT_FRAME) ? COMMIT : IDLE;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register file and commit pulse; both change on the same clk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
      cfg_update_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (reg_we && (frame_addr == 7'(i))) regs_q[i] <= frame_data;
      end
      cfg_update_q <= reg_we;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign cfg_update      = cfg_update_q;

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] sout_q, sout_d;
  logic [7:0] rd_data;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  // Select the register named by the address bits just shifted in
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 5; i++) begin
      if ((shift_d[6:0] == 7'(i)) && (7'(i) <= 7'(MAX_ADDR))) rd_data = regs_q[i];
    end
  end

  // Shift-out control: load after the 8th bit of a read frame; the first falling
  // edge after the load is skipped so the MSB is still present at the 9th rising edge
  always_comb begin
    sout_d = sout_q;
    if ((state_q == IDLE) && ncs_fall) begin
      sout_d = '0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise && (cnt_d == 5'd8) && (cnt_q != 5'd8) && !shift_d[7]) begin
        sout_d = rd_data;
      end else if (sclk_fall && (cnt_q > 5'd8)) begin
        sout_d = {sout_q[6:0], 1'b0};
      end
    end
  end

  // Shift-out register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sout_q <= '0;
    else        sout_q <= sout_d;
  end

  assign spi.cipo_out = (state_q == SHIFT) & sout_q[7];
`else
  assign spi.cipo_out = 1'b0;
`endif

endmodule
